// File: rtl/mac_tx_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : mac_tx_sched
// Description : Round-robin arbiter feeding one mac_tx; tracks txen and
//               enforces the inter-frame gap before the next grant.
// Revision    : 1.0 - initial release
// ============================================================================
module mac_tx_sched #(
    parameter int N            = 4,
    parameter int IFG_CYCLES   = 48,
    parameter int TXEN_TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req_valid,
    input  logic [16*N-1:0]      req_data,
    output logic [N-1:0]         req_ready,
    output logic [15:0]          mtx_data,
    output logic                 mtx_start,
    input  logic                 mtx_txen,
    output logic                 busy,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 timeout,
    output logic [15:0]          frames_sent
);

    localparam int c_ID_W    = $clog2(N);
    localparam int c_CNT_MAX = (IFG_CYCLES > TXEN_TIMEOUT) ? IFG_CYCLES : TXEN_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_ID_W:0] c_N = (c_ID_W + 1)'(N);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_TXEN = 3'd2,
        ST_SENDING   = 3'd3,
        ST_GAP       = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_CNT_W-1:0]  w_cnt_nxt;
    logic [c_ID_W-1:0]   r_rr;
    logic [c_ID_W-1:0]   r_grant_id;
    logic [15:0]         r_data;
    logic [15:0]         r_frames_sent;

    logic                w_any;
    logic [c_ID_W-1:0]   w_sel;
    logic [c_ID_W:0]     w_idx;
    logic [15:0]         w_sel_data;
    logic                w_grant;
    logic                w_frame_done;

    // Search starts at the rr pointer and wraps modulo N.
    always_comb begin
        w_any = 1'b0;
        w_sel = '0;
        w_idx = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, r_rr} + (c_ID_W + 1)'(k);
            if (w_idx >= c_N) begin
                w_idx = w_idx - c_N;
            end
            if (!w_any && req_valid[w_idx[c_ID_W-1:0]]) begin
                w_any = 1'b1;
                w_sel = w_idx[c_ID_W-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < N; k++) begin
            if (c_ID_W'(k) == w_sel) begin
                w_sel_data = req_data[16*k +: 16];
            end
        end
    end

    assign w_grant = (r_state == ST_IDLE) && w_any && !mtx_txen && !rst;

    always_comb begin
        req_ready = '0;
        if (w_grant) begin
            req_ready[w_sel] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        mtx_start    = 1'b0;
        timeout      = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                mtx_start   = 1'b1;
                w_cnt_nxt   = c_CNT_W'(TXEN_TIMEOUT);
                w_state_nxt = ST_WAIT_TXEN;
            end
            ST_WAIT_TXEN: begin
                if (mtx_txen) begin
                    w_state_nxt = ST_SENDING;
                end else if (r_cnt == '0) begin
                    timeout     = 1'b1;
                    w_cnt_nxt   = c_CNT_W'(IFG_CYCLES);
                    w_state_nxt = ST_GAP;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_SENDING: begin
                if (!mtx_txen) begin
                    w_frame_done = 1'b1;
                    w_cnt_nxt    = c_CNT_W'(IFG_CYCLES);
                    w_state_nxt  = ST_GAP;
                end
            end
            ST_GAP: begin
                // Counter holds the remaining gap clocks including this one.
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_rr          <= '0;
            r_grant_id    <= '0;
            r_data        <= '0;
            r_frames_sent <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_grant) begin
                r_data     <= w_sel_data;
                r_grant_id <= w_sel;
                r_rr       <= (w_sel == c_ID_W'(N - 1)) ? '0 : w_sel + 1'b1;
            end
            if (w_frame_done) begin
                r_frames_sent <= r_frames_sent + 16'd1;
            end
        end
    end

    assign busy        = (r_state != ST_IDLE);
    assign mtx_data    = r_data;
    assign grant_id    = r_grant_id;
    assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire
